// File: rtl/kbd_pkg.sv
// kbd_pkg: shared state, entry type and PS/2 event constants for the autotype scheduler
package kbd_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_SHIFT_DN, S_KEY_DN, S_HOLD, S_KEY_UP, S_SHIFT_UP, S_GAP, S_END
  } kbd_as_state_t;
  typedef struct packed {
    logic       shift;
    logic       ext;
    logic [7:0] code;
  } kbd_seq_entry_t;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_END    = 8'h00;
  localparam int K_STB = 10;
  localparam int K_PRS = 9;
  localparam int K_EXT = 8;
endpackage

// File: rtl/kbd_seq_timer.sv
// kbd_seq_timer: loadable down-counter that stops at zero
//  clk_sys, reset : clock, synchronous active-high reset
//  load, val      : load val this cycle (wins over en)
//  en             : count down by one while nonzero
//  expired        : counter is zero
module kbd_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         expired
);
  logic [W-1:0] cnt;
  assign expired = cnt == '0;
  always_ff @(posedge clk_sys)
    if (reset) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && !expired) cnt <= cnt - 1'b1;
endmodule

// File: rtl/kbd_autotype_sched.sv
// kbd_autotype_sched: injects ROM keystroke sequences into the PS/2 event stream, merged with physical keys
//  clk_sys, reset : clock, synchronous active-high reset
//  ps2_key_in     : physical events {strobe, pressed, ext, code}
//  start          : pulse, run the sequence from address 0
//  seq_addr       : ROM address, data arrives one cycle later on seq_data {shift, ext, code}
//  ps2_key_out    : merged event stream, same format as ps2_key_in
//  busy, done     : sequence running / one-cycle pulse on end or abort
module kbd_autotype_sched
  import kbd_pkg::*;
#(
  parameter int SEQ_AW       = 6,
  parameter int HOLD_CYCLES  = 1_000_000,
  parameter int GAP_CYCLES   = 500_000,
  parameter int ABORT_ON_KEY = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [10:0]       ps2_key_in,
  input  logic              start,
  output logic [SEQ_AW-1:0] seq_addr,
  input  logic [9:0]        seq_data,
  output logic [10:0]       ps2_key_out,
  output logic              busy,
  output logic              done
);
  localparam int TMAX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_HOLD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP  = TW'(GAP_CYCLES - 1);
  kbd_as_state_t state, nxt;
  kbd_seq_entry_t ent, rd;
  logic strb, rdy, abrt, phys, abort, inj_due, inj_go, tload, texp;
  logic [9:0] inj_ev;
  assign rd = seq_data;
  assign phys = ps2_key_in[K_STB] != strb;
  assign abort = (ABORT_ON_KEY != 0) && phys && ps2_key_in[K_PRS] && state != S_IDLE && state != S_END;
  // a physical event owns the output this cycle; the injector retries next cycle
  assign inj_go = inj_due && !phys;
  assign tload = inj_go && (state == S_KEY_DN || state == S_SHIFT_UP || (state == S_KEY_UP && !ent.shift));
  always_comb begin
    inj_due = state inside {S_SHIFT_DN, S_KEY_DN, S_KEY_UP, S_SHIFT_UP};
    inj_ev = state == S_SHIFT_DN ? {2'b10, SC_LSHIFT} :
             state == S_KEY_DN   ? {1'b1, ent.ext, ent.code} :
             state == S_KEY_UP   ? {1'b0, ent.ext, ent.code} : {2'b00, SC_LSHIFT};
  end
  kbd_seq_timer #(.W(TW)) u_timer (
    .clk_sys(clk_sys),
    .reset(reset),
    .load(tload),
    .en(state == S_HOLD || state == S_GAP),
    .val(state == S_KEY_DN ? T_HOLD : T_GAP),
    .expired(texp)
  );
  always_ff @(posedge clk_sys)
    if (reset) state <= S_IDLE;
    else state <= nxt;
  // abort unwinds through KEY_UP/SHIFT_UP so held keys are released before END
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:    nxt = abort ? S_END : !rdy ? S_FETCH : rd.code == SC_END ? S_END : rd.shift ? S_SHIFT_DN : S_KEY_DN;
      S_SHIFT_DN: nxt = abort ? S_END : inj_go ? S_KEY_DN : S_SHIFT_DN;
      S_KEY_DN:   nxt = abort ? (ent.shift ? S_SHIFT_UP : S_END) : inj_go ? S_HOLD : S_KEY_DN;
      S_HOLD:     nxt = abort || texp ? S_KEY_UP : S_HOLD;
      S_KEY_UP:   nxt = !inj_go ? S_KEY_UP : ent.shift ? S_SHIFT_UP : abrt ? S_END : S_GAP;
      S_SHIFT_UP: nxt = !inj_go ? S_SHIFT_UP : abrt ? S_END : S_GAP;
      S_GAP:      nxt = abort ? S_END : !texp ? S_GAP : &seq_addr ? S_END : S_FETCH;
      default:    nxt = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state != S_IDLE;
    done = state == S_END;
  end
  always_ff @(posedge clk_sys)
    if (reset) begin
      ps2_key_out <= '0;
      strb <= 1'b0;
      seq_addr <= '0;
      ent <= '0;
      rdy <= 1'b0;
      abrt <= 1'b0;
    end else begin
      strb <= ps2_key_in[K_STB];
      if (phys) ps2_key_out <= {~ps2_key_out[K_STB], ps2_key_in[9:0]};
      else if (inj_go) ps2_key_out <= {~ps2_key_out[K_STB], inj_ev};
      rdy <= state == S_FETCH && !rdy && !abort;
      if (state == S_FETCH && rdy) ent <= rd;
      if (state == S_IDLE && start) seq_addr <= '0;
      else if (state == S_GAP && texp && !abort && !(&seq_addr)) seq_addr <= seq_addr + 1'b1;
      abrt <= state == S_IDLE ? 1'b0 : abrt | abort;
    end
endmodule

// File: tb/tb_kbd_autotype_sched.sv
// tb_kbd_autotype_sched: randomized scenario tests against an event-timeline model of the scheduler
module tb_kbd_autotype_sched;
  localparam int AW = 6;
  localparam int H = 4;
  localparam int G = 2;
  logic clk = 0, reset = 1, start = 0;
  logic [10:0] ps2_key_in = '0;
  logic [AW-1:0] seq_addr;
  logic [9:0] seq_data;
  logic [10:0] ps2_key_out;
  logic busy, done;
  logic [9:0] rom [64];
  int cyc = 0, n_chk = 0, n_fail = 0, ob = 0, db = 0, exp_done = 0;
  int obs_q[$], done_q[$], exp_q[$];
  logic pstb = 0;

  always #5 clk = ~clk;

  kbd_autotype_sched #(.SEQ_AW(AW), .HOLD_CYCLES(H), .GAP_CYCLES(G), .ABORT_ON_KEY(1)) dut (
    .clk_sys(clk), .reset(reset), .ps2_key_in(ps2_key_in), .start(start), .seq_addr(seq_addr),
    .seq_data(seq_data), .ps2_key_out(ps2_key_out), .busy(busy), .done(done)
  );

  always @(posedge clk) seq_data <= rom[seq_addr];

  function automatic int pk(input int c, input logic [9:0] e);
    return (c << 10) | int'(e);
  endfunction

  // event recorder: every strobe toggle becomes {cycle, event}
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ps2_key_out[10] !== pstb) begin
      obs_q.push_back(pk(cyc, ps2_key_out[9:0]));
      pstb = ps2_key_out[10];
    end
    if (done === 1'b1) done_q.push_back(cyc);
  end

  task automatic fill(input int n, input bit sh);
    for (int a = 0; a < 64; a++)
      rom[a] = a < n ? {sh ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(1, 255))} : 10'h000;
  endtask

  task automatic mark();
    ob = obs_q.size();
    db = done_q.size();
  endtask

  task automatic pulse_start(output int e0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    e0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_q.size() == db && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  // timeline model: start/fetch at f, entry latched 2 cycles later, press 1 cycle after that,
  // key held H cycles then released, shift wraps the key, G idle cycles before the next fetch
  task automatic build(input int e0);
    int f, p;
    logic [9:0] e;
    exp_q.delete();
    f = e0;
    for (int a = 0; a < 64; a++) begin
      e = rom[a];
      if (e[7:0] == 8'h00) begin
        exp_done = f + 2;
        return;
      end
      p = f + 3;
      if (e[9]) begin
        exp_q.push_back(pk(p, 10'h212));
        p++;
      end
      exp_q.push_back(pk(p, {1'b1, e[8:0]}));
      p += H + 1;
      exp_q.push_back(pk(p, {1'b0, e[8:0]}));
      if (e[9]) begin
        p++;
        exp_q.push_back(pk(p, 10'h012));
      end
      f = p + G;
    end
    exp_done = f;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (ps2_key_out !== 11'h000) begin n_fail++; $display("FAIL reset_out: got %03h want 000", ps2_key_out); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (seq_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", seq_addr); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    int e0, got, n;
    for (int it = 0; it < 4; it++) begin
      n = it == 0 ? 1 : $urandom_range(1, 4);
      if (it == 0) begin
        fill(0, 0);
        rom[0] = 10'h14B;
      end else fill(n, 1);
      mark();
      pulse_start(e0);
      build(e0);
      wait_done(400);
      n_chk++; if (obs_q.size() - ob !== exp_q.size()) begin n_fail++; $display("FAIL seq_count: got %0d events want %0d", obs_q.size() - ob, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
        n_chk++;
        if (obs_q[ob+i] !== exp_q[i]) begin n_fail++; $display("FAIL seq_ev%0d: got cyc %0d ev %03h want cyc %0d ev %03h", i, obs_q[ob+i] >>> 10, obs_q[ob+i] & 1023, exp_q[i] >>> 10, exp_q[i] & 1023); end
      end
      got = done_q.size() > db ? done_q[db] : -1;
      n_chk++; if (done_q.size() - db !== 1 || got !== exp_done) begin n_fail++; $display("FAIL seq_done: got %0d pulses at cyc %0d want 1 at cyc %0d", done_q.size() - db, got, exp_done); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy: got %b want 0", busy); end
      n_chk++; if (seq_addr !== AW'(n)) begin n_fail++; $display("FAIL seq_addr: got %0d want %0d", seq_addr, n); end
    end
  endtask

  task automatic test_contention();
    int e0, got;
    fill(1, 0);
    mark();
    pulse_start(e0);
    repeat (2) @(negedge clk);
    ps2_key_in = {~ps2_key_in[10], 10'h01C};
    build(e0 + 1);
    exp_q.push_front(pk(e0 + 3, 10'h01C));
    wait_done(400);
    n_chk++; if (obs_q.size() - ob !== exp_q.size()) begin n_fail++; $display("FAIL cont_count: got %0d events want %0d", obs_q.size() - ob, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[ob+i] !== exp_q[i]) begin n_fail++; $display("FAIL cont_ev%0d: got cyc %0d ev %03h want cyc %0d ev %03h", i, obs_q[ob+i] >>> 10, obs_q[ob+i] & 1023, exp_q[i] >>> 10, exp_q[i] & 1023); end
    end
    got = done_q.size() > db ? done_q[db] : -1;
    n_chk++; if (done_q.size() - db !== 1 || got !== exp_done) begin n_fail++; $display("FAIL cont_done: got %0d pulses at cyc %0d want 1 at cyc %0d", done_q.size() - db, got, exp_done); end
  endtask

  task automatic test_abort();
    int e0, got, k, x;
    for (int sh = 0; sh < 2; sh++) begin
      fill(3, 0);
      rom[0] = {1'(sh), 1'b0, 8'h29};
      mark();
      pulse_start(e0);
      k = e0 + 3 + sh;
      x = k + $urandom_range(1, H);
      repeat (x - 1 - e0) @(negedge clk);
      ps2_key_in = {~ps2_key_in[10], 10'h21C};
      exp_q.delete();
      if (sh == 1) exp_q.push_back(pk(e0 + 3, 10'h212));
      exp_q.push_back(pk(k, 10'h229));
      exp_q.push_back(pk(x, 10'h21C));
      exp_q.push_back(pk(x + 1, 10'h029));
      if (sh == 1) exp_q.push_back(pk(x + 2, 10'h012));
      exp_done = x + 1 + sh;
      wait_done(400);
      n_chk++; if (obs_q.size() - ob !== exp_q.size()) begin n_fail++; $display("FAIL abort_count: got %0d events want %0d", obs_q.size() - ob, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
        n_chk++;
        if (obs_q[ob+i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_ev%0d: got cyc %0d ev %03h want cyc %0d ev %03h", i, obs_q[ob+i] >>> 10, obs_q[ob+i] & 1023, exp_q[i] >>> 10, exp_q[i] & 1023); end
      end
      got = done_q.size() > db ? done_q[db] : -1;
      n_chk++; if (done_q.size() - db !== 1 || got !== exp_done) begin n_fail++; $display("FAIL abort_done: got %0d pulses at cyc %0d want 1 at cyc %0d", done_q.size() - db, got, exp_done); end
      n_chk++; if (seq_addr !== '0) begin n_fail++; $display("FAIL abort_addr: got %0d want 0", seq_addr); end
    end
  endtask

  task automatic test_full_rom();
    int e0, got, n;
    bit nz, wrap;
    fill(64, 1);
    mark();
    pulse_start(e0);
    build(e0);
    n = 0; nz = 0; wrap = 0;
    while (done_q.size() == db && n < 3000) begin
      @(negedge clk);
      n++;
      if (seq_addr != 0) nz = 1;
      else if (nz) wrap = 1;
    end
    repeat (3) @(negedge clk);
    n_chk++; if (obs_q.size() - ob !== exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d events want %0d", obs_q.size() - ob, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[ob+i] !== exp_q[i]) begin n_fail++; $display("FAIL full_ev%0d: got cyc %0d ev %03h want cyc %0d ev %03h", i, obs_q[ob+i] >>> 10, obs_q[ob+i] & 1023, exp_q[i] >>> 10, exp_q[i] & 1023); end
    end
    got = done_q.size() > db ? done_q[db] : -1;
    n_chk++; if (done_q.size() - db !== 1 || got !== exp_done) begin n_fail++; $display("FAIL full_done: got %0d pulses at cyc %0d want 1 at cyc %0d", done_q.size() - db, got, exp_done); end
    n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL full_wrap: got %b want 0", wrap); end
    n_chk++; if (seq_addr !== 6'd63) begin n_fail++; $display("FAIL full_addr: got %0d want 63", seq_addr); end
  endtask

  task automatic test_reset_mid();
    int e0, got;
    fill(2, 0);
    mark();
    pulse_start(e0);
    repeat (5) @(negedge clk);
    reset = 1;
    ps2_key_in = '0;
    @(negedge clk);
    n_chk++; if (ps2_key_out !== 11'h000) begin n_fail++; $display("FAIL rmid_out: got %03h want 000", ps2_key_out); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", done); end
    reset = 0;
    @(negedge clk);
    mark();
    pulse_start(e0);
    build(e0);
    wait_done(400);
    n_chk++; if (obs_q.size() - ob !== exp_q.size()) begin n_fail++; $display("FAIL rmid_count: got %0d events want %0d", obs_q.size() - ob, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[ob+i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_ev%0d: got cyc %0d ev %03h want cyc %0d ev %03h", i, obs_q[ob+i] >>> 10, obs_q[ob+i] & 1023, exp_q[i] >>> 10, exp_q[i] & 1023); end
    end
    got = done_q.size() > db ? done_q[db] : -1;
    n_chk++; if (done_q.size() - db !== 1 || got !== exp_done) begin n_fail++; $display("FAIL rmid_done2: got %0d pulses at cyc %0d want 1 at cyc %0d", done_q.size() - db, got, exp_done); end
  endtask

  task automatic test_start_busy();
    int e0, got, n;
    fill(3, 1);
    mark();
    pulse_start(e0);
    build(e0);
    n = 0;
    while (done_q.size() == db && n < 1000) begin
      @(negedge clk);
      start = busy && $urandom_range(0, 2) == 0;
      n++;
    end
    start = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (obs_q.size() - ob !== exp_q.size()) begin n_fail++; $display("FAIL sbusy_count: got %0d events want %0d", obs_q.size() - ob, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[ob+i] !== exp_q[i]) begin n_fail++; $display("FAIL sbusy_ev%0d: got cyc %0d ev %03h want cyc %0d ev %03h", i, obs_q[ob+i] >>> 10, obs_q[ob+i] & 1023, exp_q[i] >>> 10, exp_q[i] & 1023); end
    end
    got = done_q.size() > db ? done_q[db] : -1;
    n_chk++; if (done_q.size() - db !== 1 || got !== exp_done) begin n_fail++; $display("FAIL sbusy_done: got %0d pulses at cyc %0d want 1 at cyc %0d", done_q.size() - db, got, exp_done); end
    n_chk++; if (seq_addr !== 6'd3) begin n_fail++; $display("FAIL sbusy_addr: got %0d want 3", seq_addr); end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = 10'h000;
    test_reset();
    test_sequence();
    test_contention();
    test_abort();
    test_full_rom();
    test_reset_mid();
    test_start_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
